approx_mult_controller: RTL and testbench

Sequencing FSM for the 16x16 leading-one approximate multiplier datapath. On `start` it loads both operands and left-normalises A, then B, counting every shift in the datapath's 5-bit up/down counter. It then multiplies the two top bytes into the result register and right-shifts that result once per counted shift. The block sits beside the datapath in the multiplier top; the top-level `A`, `B` and `mult_result` go straight to the datapath.

---
 rtl/approx_mult_pkg.sv | 16 +
 rtl/approx_mult_controller.sv | 108 ++++++++++
 tb/tb_approx_mult_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the leading-one approximate multiplier.
package approx_mult_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SHA  = 3'd2,
        S_SHB  = 3'd3,
        S_MUL  = 3'd4,
        S_SHR  = 3'd5,
        S_DONE = 3'd6
    } ctrl_state_t;

    localparam logic [3:0] MAX_SHIFT = 4'd15;

endpackage

// File: rtl/approx_mult_controller.sv
// Sequencing FSM for the 16x16 leading-one approximate multiplier datapath:
// normalise A then B, multiply the top bytes, then undo the counted shifts.
module approx_mult_controller
    import approx_mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic DoneA,
    input  logic DoneB,
    input  logic down_done,
    output logic loadA,
    output logic loadB,
    output logic ShlA,
    output logic ShlB,
    output logic rst5,
    output logic cntU,
    output logic cntD,
    output logic loadOut,
    output logic ShrOut,
    output logic busy,
    output logic done
);

    ctrl_state_t state_q, state_d;
    logic [3:0]  guard_q, guard_d;

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        loadA   = 1'b0;
        loadB   = 1'b0;
        ShlA    = 1'b0;
        ShlB    = 1'b0;
        rst5    = 1'b0;
        cntU    = 1'b0;
        cntD    = 1'b0;
        loadOut = 1'b0;
        ShrOut  = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                loadA   = 1'b1;
                loadB   = 1'b1;
                rst5    = 1'b1;
                guard_d = 4'd0;
                state_d = S_SHA;
            end
            // The guard bounds normalisation of a zero operand to MAX_SHIFT steps.
            S_SHA: begin
                if (!DoneA && (guard_q != MAX_SHIFT)) begin
                    ShlA    = 1'b1;
                    cntU    = 1'b1;
                    guard_d = guard_q + 4'd1;
                end else begin
                    guard_d = 4'd0;
                    state_d = S_SHB;
                end
            end
            S_SHB: begin
                if (!DoneB && (guard_q != MAX_SHIFT)) begin
                    ShlB    = 1'b1;
                    cntU    = 1'b1;
                    guard_d = guard_q + 4'd1;
                end else begin
                    guard_d = 4'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                loadOut = 1'b1;
                state_d = S_SHR;
            end
            S_SHR: begin
                if (!down_done) begin
                    ShrOut = 1'b1;
                    cntD   = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                guard_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            guard_q <= 4'd0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

endmodule

// File: tb/tb_approx_mult_controller.sv
// Bench for approx_mult_controller with a behavioural datapath alongside it.
module tb_approx_mult_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic DoneA, DoneB, down_done;
    logic loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut, busy, done;

    logic [15:0] a_in = 16'h0, b_in = 16'h0;
    logic [15:0] a_q = 16'h0, b_q = 16'h0, res_q = 16'h0;
    logic [4:0]  cnt_q = 5'd0;

    int n_cmp = 0;
    int n_fail = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    approx_mult_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .DoneA(DoneA), .DoneB(DoneB), .down_done(down_done),
        .loadA(loadA), .loadB(loadB), .ShlA(ShlA), .ShlB(ShlB),
        .rst5(rst5), .cntU(cntU), .cntD(cntD),
        .loadOut(loadOut), .ShrOut(ShrOut), .busy(busy), .done(done)
    );

    // Datapath model driven by the controller
    assign DoneA     = a_q[15];
    assign DoneB     = b_q[15];
    assign down_done = (cnt_q == 5'd0);

    always @(posedge clk) begin
        if (loadA) a_q <= a_in; else if (ShlA) a_q <= a_q << 1;
        if (loadB) b_q <= b_in; else if (ShlB) b_q <= b_q << 1;
        if (rst5) cnt_q <= 5'd0;
        else if (cntU) cnt_q <= cnt_q + 5'd1;
        else if (cntD) cnt_q <= cnt_q - 5'd1;
        if (loadOut) res_q <= 16'(a_q[15:8]) * 16'(b_q[15:8]);
        else if (ShrOut) res_q <= res_q >> 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exclusivity and single-cycle done checked every cycle
    always @(negedge clk) begin
        chk("excl_shl", 32'(ShlA & ShlB), 32'd0);
        chk("excl_cnt", 32'(cntU & cntD), 32'd0);
        chk("excl_out", 32'(loadOut & ShrOut), 32'd0);
        chk("done_pulse", 32'(done & done_prev), 32'd0);
        done_prev = done;
    end

    function automatic logic [10:0] outs();
        return {loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut, busy, done};
    endfunction

    // Called at a negedge with the FSM in IDLE; returns at the negedge after done.
    // p1/p2 name cycles in which a stray start pulse is driven (0 = none).
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input int exp_cyc,
                          input int exp_sa, input int exp_sb, input int p1, input int p2);
        int cyc_done = 0;
        int nla = 0, nlb = 0, nshr = 0, nload = 0;
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_load"}, 32'({loadA, loadB, rst5, busy}), 32'hF);
        for (int c = 1; c <= 100; c++) begin
            nla += int'(ShlA);
            nlb += int'(ShlB);
            nshr += int'(ShrOut);
            nload += int'(loadA);
            if (done) begin
                cyc_done = c;
                break;
            end
            start = (c == p1 || c == p2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, 32'(cyc_done), 32'(exp_cyc));
        chk({name, "_shla"}, 32'(nla), 32'(exp_sa));
        chk({name, "_shlb"}, 32'(nlb), 32'(exp_sb));
        chk({name, "_shr"}, 32'(nshr), 32'(exp_sa + exp_sb));
        chk({name, "_loads"}, 32'(nload), 32'd1);
        chk({name, "_result"}, 32'(res_q), 32'(exp_res));
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_result_hold"}, 32'(res_q), 32'(exp_res));
    endtask

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          cyc;
        int          sa;
        int          sb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nld, ndn;
        vecs[0] = '{"norm",    16'h8000, 16'h8000, 16'h4000,  6,  0,  0};
        vecs[1] = '{"f0_f00",  16'h00F0, 16'h0F00, 16'h000E, 30,  8,  4};
        vecs[2] = '{"zero_a",  16'h0000, 16'h8000, 16'h0000, 36, 15,  0};
        vecs[3] = '{"max",     16'h0001, 16'h0001, 16'h0000, 66, 15, 15};
        vecs[4] = '{"ff_ff",   16'hFFFF, 16'h00FF, 16'h00FE, 22,  0,  8};
        vecs[5] = '{"mixed",   16'h1234, 16'h5678, 16'h0616, 14,  3,  1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs()), 32'd0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].cyc, vecs[i].sa, vecs[i].sb, 0, 0);

        // Stray start pulses in SHA (cycle 5) and SHR (cycle 20)
        run_op("stray", 16'h00F0, 16'h0F00, 16'h000E, 30, 8, 4, 5, 20);

        // start held high: three back-to-back operations with one-cycle IDLE gaps
        a_in = 16'h8000;
        b_in = 16'h8000;
        start = 1'b1;
        nld = 0;
        ndn = 0;
        @(posedge clk);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            nld += int'(loadA);
            ndn += int'(done);
            if (c == 7 || c == 14) chk("held_gap_idle", 32'(busy), 32'd0);
            if (c == 8 || c == 15) chk("held_reload", 32'(loadA), 32'd1);
        end
        start = 1'b0;
        chk("held_loads", 32'(nld), 32'd3);
        chk("held_dones", 32'(ndn), 32'd3);
        @(negedge clk);

        // Synchronous reset in the middle of SHR
        a_in = 16'h00F0;
        b_in = 16'h0F00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_shr", 32'(ShrOut), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        chk("post_rst_idle", 32'(outs()), 32'd0);
        run_op("after_rst", 16'h1234, 16'h5678, 16'h0616, 14, 3, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
